// File: rtl/spi_note_decoder.sv
// SPI mode-0 slave that turns 3-byte MIDI-style note frames into single-cycle note events
// and returns a {DEVICE_ID, frame_count, error_count} status word on MISO.
module spi_note_decoder #(
  parameter int         NUM_VOICES   = 64,
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter bit         OMNI         = 1'b0,
  parameter logic [7:0] DEVICE_ID    = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_spi_sclk,
  input  logic       i_spi_mosi,
  input  logic       i_spi_cs_n,
  output logic       o_spi_miso,
  output logic       o_SPI_flag,
  output logic       o_SPI_note_status,
  output logic [7:0] o_SPI_voice_index,
  output logic [6:0] o_SPI_velocity,
  output logic       o_frame_error
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

  localparam logic [8:0] NV = 9'(NUM_VOICES);

  // [0] metastability stage, [1] synchronised value, [2] history for edge detection
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;

  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] rx_q, rx_d;
  logic [22:0] miso_sr_q, miso_sr_d;
  logic        miso_q, miso_d;
  logic        flag_q, flag_d;
  logic        err_q, err_d;
  logic        note_q, note_d;
  logic [7:0]  voice_q, voice_d;
  logic [6:0]  vel_q, vel_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  error_cnt_q, error_cnt_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_high, frame_ok;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], i_spi_sclk};
    cs_sync_d   = {cs_sync_q[1:0], i_spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], i_spi_mosi};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_high   = cs_sync_q[1];

  assign frame_ok = (bit_cnt_q == 5'd24)
                  && ((rx_q[23:20] == 4'h9) || (rx_q[23:20] == 4'h8))
                  && (OMNI || (rx_q[19:16] == MIDI_CHANNEL))
                  && ({1'b0, rx_q[15:8]} < NV)
                  && !rx_q[7];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    miso_sr_d   = miso_sr_q;
    miso_d      = miso_q;
    flag_d      = 1'b0;
    err_d       = 1'b0;
    note_d      = note_q;
    voice_d     = voice_q;
    vel_d       = vel_q;
    frame_cnt_d = frame_cnt_q;
    error_cnt_d = error_cnt_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = RECV;
      end
      RECV: begin
        if (cs_rise) begin
          state_d = CHECK;
          if (frame_ok) begin
            flag_d      = 1'b1;
            note_d      = (rx_q[23:20] == 4'h9) && (rx_q[6:0] != 7'd0);
            voice_d     = rx_q[15:8];
            vel_d       = rx_q[6:0];
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            err_d       = 1'b1;
            error_cnt_d = error_cnt_q + 8'd1;
          end
        end else if (!cs_high) begin
          if (sclk_rise) begin
            rx_d = {rx_q[22:0], mosi_sync_q[1]};
            if (bit_cnt_q != 5'd25) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (sclk_fall) begin
            miso_d    = miso_sr_q[22];
            miso_sr_d = {miso_sr_q[21:0], 1'b0};
          end
        end
      end
      CHECK: begin
        // a select that drops right after the previous frame is picked up here
        state_d = cs_fall ? RECV : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // counters were already bumped on the closing edge, so CHECK sees fresh values
    if (cs_fall && (state_q != RECV)) begin
      bit_cnt_d = 5'd0;
      miso_d    = DEVICE_ID[7];
      miso_sr_d = {DEVICE_ID[6:0], frame_cnt_q, error_cnt_q};
    end

    if (cs_high) miso_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      rx_q        <= 24'd0;
      miso_sr_q   <= 23'd0;
      miso_q      <= 1'b0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      note_q      <= 1'b0;
      voice_q     <= 8'd0;
      vel_q       <= 7'd0;
      frame_cnt_q <= 8'd0;
      error_cnt_q <= 8'd0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      note_q      <= note_d;
      voice_q     <= voice_d;
      vel_q       <= vel_d;
      frame_cnt_q <= frame_cnt_d;
      error_cnt_q <= error_cnt_d;
    end
  end

  assign o_spi_miso        = miso_q;
  assign o_SPI_flag        = flag_q;
  assign o_SPI_note_status = note_q;
  assign o_SPI_voice_index = voice_q;
  assign o_SPI_velocity    = vel_q;
  assign o_frame_error     = err_q;

endmodule

// File: tb/tb_spi_note_decoder.sv
// Directed bench for spi_note_decoder: a channel-0 instance and an OMNI instance share SCLK/MOSI.
module tb_spi_note_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n0 = 1'b1;
  logic       cs_n1 = 1'b1;

  logic       miso0, flag0, note0, err0;
  logic [7:0] vi0;
  logic [6:0] vel0;
  logic       miso1, flag1, note1, err1;
  logic [7:0] vi1;
  logic [6:0] vel1;

  int n_checks = 0;
  int n_fail   = 0;
  int nf0 = 0, ne0 = 0, nf1 = 0, ne1 = 0;

  always #5 clk = ~clk;

  spi_note_decoder #(.NUM_VOICES(64), .MIDI_CHANNEL(4'd0), .OMNI(1'b0), .DEVICE_ID(8'hA5)) dut (
    .i_clk(clk), .i_reset(rst), .i_spi_sclk(sclk), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n0),
    .o_spi_miso(miso0), .o_SPI_flag(flag0), .o_SPI_note_status(note0),
    .o_SPI_voice_index(vi0), .o_SPI_velocity(vel0), .o_frame_error(err0)
  );

  spi_note_decoder #(.NUM_VOICES(64), .MIDI_CHANNEL(4'd0), .OMNI(1'b1), .DEVICE_ID(8'hA5)) dut_omni (
    .i_clk(clk), .i_reset(rst), .i_spi_sclk(sclk), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n1),
    .o_spi_miso(miso1), .o_SPI_flag(flag1), .o_SPI_note_status(note1),
    .o_SPI_voice_index(vi1), .o_SPI_velocity(vel1), .o_frame_error(err1)
  );

  // pulse-cycle counters; a pulse wider than one cycle shows up as an extra count
  always @(posedge clk) begin
    if (flag0) nf0++;
    if (err0)  ne0++;
    if (flag1) nf1++;
    if (err1)  ne1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input int which, input logic v);
    if (which == 0) cs_n0 = v;
    else            cs_n1 = v;
  endtask

  // bit k of the frame goes out MSB first; MISO is sampled just before each SCLK rise
  task automatic shift_bits(input int which, input logic [23:0] d, input int first, input int n,
                            inout logic [23:0] mw);
    for (int k = first; k < first + n; k++) begin
      mosi = d[23-k];
      #60;
      mw = {mw[22:0], (which == 0) ? miso0 : miso1};
      sclk = 1'b1;
      #60;
      sclk = 1'b0;
    end
  endtask

  // raises select and watches up to 10 cycles for a flag/error pulse
  task automatic close_frame(input int which, output int lat);
    #60;
    set_cs(which, 1'b1);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && ((which == 0) ? (flag0 | err0) : (flag1 | err1))) lat = c;
    end
  endtask

  task automatic frame(input int which, input logic [23:0] d, input int nb,
                       output logic [23:0] mw, output int df, output int de, output int lat);
    int f_start, e_start;
    f_start = (which == 0) ? nf0 : nf1;
    e_start = (which == 0) ? ne0 : ne1;
    mw = 24'd0;
    set_cs(which, 1'b0);
    shift_bits(which, d, 0, nb, mw);
    close_frame(which, lat);
    df = ((which == 0) ? nf0 : nf1) - f_start;
    de = ((which == 0) ? ne0 : ne1) - e_start;
  endtask

  initial begin
    logic [23:0] mw;
    int df, de, lat, f_start, e_start;

    do_reset();
    check("rst_flag",  {31'd0, flag0}, 32'd0);
    check("rst_note",  {31'd0, note0}, 32'd0);
    check("rst_vi",    {24'd0, vi0},   32'd0);
    check("rst_vel",   {25'd0, vel0},  32'd0);
    check("rst_err",   {31'd0, err0},  32'd0);
    check("rst_miso",  {31'd0, miso0}, 32'd0);

    // 1: basic note on, status word straight after reset
    frame(0, 24'h900564, 24, mw, df, de, lat);
    check("t1_flags",  df, 1);
    check("t1_errs",   de, 0);
    check("t1_note",   {31'd0, note0}, 32'd1);
    check("t1_vi",     {24'd0, vi0},   32'd5);
    check("t1_vel",    {25'd0, vel0},  32'd100);
    check("t1_miso",   {8'd0, mw},     32'hA50000);
    check("t1_lat_le4", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    check("idle_miso", {31'd0, miso0}, 32'd0);

    // 2: explicit note off, then note on with zero velocity
    frame(0, 24'h800540, 24, mw, df, de, lat);
    check("t2a_flags", df, 1);
    check("t2a_note",  {31'd0, note0}, 32'd0);
    check("t2a_vi",    {24'd0, vi0},   32'd5);
    check("t2a_vel",   {25'd0, vel0},  32'h40);
    frame(0, 24'h900700, 24, mw, df, de, lat);
    check("t2b_flags", df, 1);
    check("t2b_note",  {31'd0, note0}, 32'd0);
    check("t2b_vi",    {24'd0, vi0},   32'd7);
    check("t2b_miso",  {8'd0, mw},     32'hA50200);

    // 3: index == NUM_VOICES, wrong channel, short frame
    do_reset();
    frame(0, 24'h904010, 24, mw, df, de, lat);
    check("t3a_flags", df, 0);
    check("t3a_errs",  de, 1);
    frame(0, 24'h910110, 24, mw, df, de, lat);
    check("t3b_flags", df, 0);
    check("t3b_errs",  de, 1);
    frame(0, 24'h900500, 16, mw, df, de, lat);
    check("t3c_flags", df, 0);
    check("t3c_errs",  de, 1);
    check("t3_vi_hold", {24'd0, vi0}, 32'd0);
    frame(0, 24'h903F01, 24, mw, df, de, lat);
    check("t3d_miso",  {8'd0, mw},     32'hA50003);
    check("t3d_flags", df, 1);
    check("t3d_vi63",  {24'd0, vi0},   32'd63);
    // bad message type, velocity bit 7 set, zero-bit abort
    frame(0, 24'hA00101, 24, mw, df, de, lat);
    check("t3e_errs",  de, 1);
    frame(0, 24'h900181, 24, mw, df, de, lat);
    check("t3f_errs",  de, 1);
    frame(0, 24'h000000, 0, mw, df, de, lat);
    check("t3g_abort", de, 1);
    check("t3g_flags", df, 0);
    check("t3_hold_vi",  {24'd0, vi0},  32'd63);
    check("t3_hold_vel", {25'd0, vel0}, 32'd1);
    frame(0, 24'h900101, 24, mw, df, de, lat);
    check("t3h_miso",  {8'd0, mw},     32'hA50106);

    // 4: OMNI instance accepts channel 15
    frame(1, 24'h9F027F, 24, mw, df, de, lat);
    check("t4_flags",  df, 1);
    check("t4_errs",   de, 0);
    check("t4_note",   {31'd0, note1}, 32'd1);
    check("t4_vi",     {24'd0, vi1},   32'd2);
    check("t4_vel",    {25'd0, vel1},  32'd127);

    // 5: status word after two good frames
    do_reset();
    frame(0, 24'h900101, 24, mw, df, de, lat);
    frame(0, 24'h900202, 24, mw, df, de, lat);
    frame(0, 24'h900303, 24, mw, df, de, lat);
    check("t5_miso",   {8'd0, mw},     32'hA50200);
    check("t5_vi",     {24'd0, vi0},   32'd3);

    // 6: reset in the middle of a frame
    do_reset();
    f_start = nf0;
    e_start = ne0;
    mw = 24'd0;
    cs_n0 = 1'b0;
    shift_bits(0, 24'h900564, 0, 10, mw);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    shift_bits(0, 24'h900564, 10, 14, mw);
    close_frame(0, lat);
    check("t6_no_flag", nf0 - f_start, 0);
    check("t6_no_err",  ne0 - e_start, 0);
    frame(0, 24'h900564, 24, mw, df, de, lat);
    check("t6_miso",   {8'd0, mw},     32'hA50000);
    check("t6_flags",  df, 1);
    check("t6_errs",   de, 0);
    check("t6_vi",     {24'd0, vi0},   32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
